// File: rtl/rat_ckpt.sv
// rat_ckpt: register alias table with intra-group bypass, CDB wakeup, branch checkpoints and RRAT rollback
module rat_ckpt #(
  parameter int ARCH_REGS = 32,
  parameter int PREG_IDX_WIDTH = 6,
  parameter int SCALAR = 2,
  parameter int CDB_WIDTH = 2,
  parameter int NUM_CKPT = 4,
  localparam int AW = $clog2(ARCH_REGS),
  localparam int PW = PREG_IDX_WIDTH,
  localparam int CW = $clog2(NUM_CKPT)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [SCALAR-1:0]         rename_valid,
  input  logic [SCALAR*AW-1:0]      rename_dest,
  input  logic [SCALAR*PW-1:0]      rename_tag,
  input  logic [2*SCALAR*AW-1:0]    src_addr,
  output logic [2*SCALAR*PW-1:0]    src_tag,
  output logic [2*SCALAR-1:0]       src_ready,
  output logic [SCALAR*PW-1:0]      told,
  input  logic [SCALAR-1:0]         ckpt_req,
  output logic [SCALAR*CW-1:0]      ckpt_id,
  output logic                      ckpt_full,
  input  logic                      ckpt_release,
  input  logic                      restore_valid,
  input  logic [CW-1:0]             restore_id,
  input  logic                      rollback,
  input  logic [ARCH_REGS*PW-1:0]   rrat_tag,
  input  logic [CDB_WIDTH-1:0]      cdb_valid,
  input  logic [CDB_WIDTH*PW-1:0]   cdb_tag
);
  localparam logic [CW:0] NC = (CW+1)'(NUM_CKPT);
  localparam logic [CW:0] SC = (CW+1)'(SCALAR);
  logic [PW-1:0]        map_q [ARCH_REGS];
  logic [ARCH_REGS-1:0] rdy_q;
  logic [PW-1:0]        snap_map [NUM_CKPT][ARCH_REGS];
  logic [ARCH_REGS-1:0] snap_rdy [NUM_CKPT];
  logic [NUM_CKPT-1:0]  snap_vld;
  logic [CW-1:0]        head, tail;
  logic [CW:0]          count;
  logic [PW-1:0]        wm [ARCH_REGS];
  logic [ARCH_REGS-1:0] wr;
  logic [PW-1:0]        stage_map [SCALAR][ARCH_REGS];
  logic [ARCH_REGS-1:0] stage_rdy [SCALAR];
  logic [CW-1:0]        ids [SCALAR];
  logic [CW:0]          n_alloc;
  logic                 rel;

  function automatic logic hit(input logic [PW-1:0] t);
    hit = 1'b0;
    for (int c = 0; c < CDB_WIDTH; c++) hit |= cdb_valid[c] && cdb_tag[c*PW +: PW] == t;
  endfunction

  assign ckpt_full = (NC - count) < SC;
  assign rel = ckpt_release && count != '0;

  // older slots in the group override the table; a bypassed tag is never ready
  always_comb begin
    for (int s = 0; s < 2 * SCALAR; s++) begin
      src_tag[s*PW +: PW] = map_q[src_addr[s*AW +: AW]];
      src_ready[s] = rdy_q[src_addr[s*AW +: AW]] | hit(map_q[src_addr[s*AW +: AW]]);
      for (int j = 0; j < s / 2; j++)
        if (rename_valid[j] && rename_dest[j*AW +: AW] == src_addr[s*AW +: AW]) begin
          src_tag[s*PW +: PW] = rename_tag[j*PW +: PW];
          src_ready[s] = 1'b0;
        end
    end
    for (int i = 0; i < SCALAR; i++) begin
      told[i*PW +: PW] = map_q[rename_dest[i*AW +: AW]];
      for (int j = 0; j < i; j++)
        if (rename_valid[j] && rename_dest[j*AW +: AW] == rename_dest[i*AW +: AW])
          told[i*PW +: PW] = rename_tag[j*PW +: PW];
    end
  end

  // map state after each slot, with wakeups applied before renames so renames win
  always_comb begin
    for (int d = 0; d < ARCH_REGS; d++) begin
      wm[d] = map_q[d];
      wr[d] = rdy_q[d] | hit(map_q[d]);
    end
    for (int i = 0; i < SCALAR; i++) begin
      if (rename_valid[i]) begin
        wm[rename_dest[i*AW +: AW]] = rename_tag[i*PW +: PW];
        wr[rename_dest[i*AW +: AW]] = 1'b0;
      end
      stage_map[i] = wm;
      stage_rdy[i] = wr;
    end
  end

  always_comb begin
    n_alloc = '0;
    for (int i = 0; i < SCALAR; i++) begin
      ids[i] = tail + n_alloc[CW-1:0];
      ckpt_id[i*CW +: CW] = ids[i];
      n_alloc = n_alloc + {{CW{1'b0}}, ckpt_req[i]};
    end
    if (ckpt_full) n_alloc = '0;
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < NUM_CKPT; k++)
      for (int d = 0; d < ARCH_REGS; d++)
        snap_rdy[k][d] <= snap_rdy[k][d] | hit(snap_map[k][d]);
    if (reset) begin
      for (int d = 0; d < ARCH_REGS; d++) map_q[d] <= PW'(d);
      rdy_q <= '1;
      head <= '0;
      tail <= '0;
      count <= '0;
      snap_vld <= '0;
    end else if (rollback) begin
      for (int d = 0; d < ARCH_REGS; d++) map_q[d] <= rrat_tag[d*PW +: PW];
      rdy_q <= '1;
      head <= '0;
      tail <= '0;
      count <= '0;
      snap_vld <= '0;
    end else if (restore_valid) begin
      for (int d = 0; d < ARCH_REGS; d++) begin
        map_q[d] <= snap_map[restore_id][d];
        rdy_q[d] <= snap_rdy[restore_id][d] | hit(snap_map[restore_id][d]);
      end
      tail <= restore_id;
      count <= {1'b0, restore_id - head};
      for (int k = 0; k < NUM_CKPT; k++)
        if (CW'(k) - head >= restore_id - head) snap_vld[k] <= 1'b0;
    end else begin
      map_q <= wm;
      rdy_q <= wr;
      head <= head + CW'(rel);
      tail <= tail + n_alloc[CW-1:0];
      count <= count + n_alloc - (CW+1)'(rel);
      if (rel) snap_vld[head] <= 1'b0;
      for (int i = 0; i < SCALAR; i++)
        if (ckpt_req[i] && !ckpt_full) begin
          snap_vld[ids[i]] <= 1'b1;
          snap_map[ids[i]] <= stage_map[i];
          snap_rdy[ids[i]] <= stage_rdy[i];
        end
    end
  end

  always_ff @(posedge clock)
    if (!reset && !rollback) begin
      if (restore_valid) begin
        assert (snap_vld[restore_id]);
      end else begin
        assert (!ckpt_full || ckpt_req == '0);
      end
    end
endmodule

// File: tb/tb_rat_ckpt.sv
// tb_rat_ckpt: vector table, directed checkpoint sequences and random traffic against a queue-based model
module tb_rat_ckpt;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] rv, creq, cv, rid;
  logic [9:0] rdest;
  logic [11:0] rtag, ct, told_o;
  logic [19:0] srca;
  logic [23:0] stag;
  logic [3:0] srdy, cid;
  logic full, rel, rs, rb;
  logic [191:0] rrat;
  int checks = 0, fails = 0;
  logic [5:0] mm [32];
  bit mr [32];
  logic [5:0] sm [4][32];
  bit sr [4][32];
  int ckq[$];
  int mtail;

  typedef struct packed {
    logic [1:0] rv;
    logic [9:0] dest;
    logic [11:0] tag;
    logic [19:0] src;
    logic [1:0] cv;
    logic [11:0] ct;
    logic [23:0] e_tag;
    logic [3:0] e_rdy;
    logic [11:0] e_told;
  } vec_t;
  vec_t tv [8];

  always #5 clk = ~clk;

  rat_ckpt dut (
    .clock(clk), .reset(rst), .rename_valid(rv), .rename_dest(rdest), .rename_tag(rtag),
    .src_addr(srca), .src_tag(stag), .src_ready(srdy), .told(told_o), .ckpt_req(creq),
    .ckpt_id(cid), .ckpt_full(full), .ckpt_release(rel), .restore_valid(rs), .restore_id(rid),
    .rollback(rb), .rrat_tag(rrat), .cdb_valid(cv), .cdb_tag(ct)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    rv = 0; rdest = 0; rtag = 0; srca = 0; creq = 0; rel = 0; rs = 0; rid = 0; rb = 0; cv = 0; ct = 0;
  endtask

  function automatic bit mhit(input logic [5:0] t);
    for (int c = 0; c < 2; c++) if (cv[c] && ct[c*6 +: 6] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset(input bit use_rrat);
    for (int d = 0; d < 32; d++) begin
      mm[d] = use_rrat ? rrat[d*6 +: 6] : 6'(d);
      mr[d] = 1'b1;
    end
    ckq.delete();
    mtail = 0;
  endtask

  task automatic tick();
    logic [23:0] et;
    logic [3:0] er, ei, im;
    logic [11:0] eo;
    bit ef;
    int n, id;
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      logic [4:0] a;
      a = srca[s*5 +: 5];
      et[s*6 +: 6] = mm[a];
      er[s] = mr[a] | mhit(mm[a]);
      for (int j = 0; j < s / 2; j++)
        if (rv[j] && rdest[j*5 +: 5] == a) begin
          et[s*6 +: 6] = rtag[j*6 +: 6];
          er[s] = 1'b0;
        end
    end
    for (int i = 0; i < 2; i++) begin
      eo[i*6 +: 6] = mm[rdest[i*5 +: 5]];
      if (i == 1 && rv[0] && rdest[4:0] == rdest[9:5]) eo[11:6] = rtag[5:0];
    end
    ef = (4 - ckq.size()) < 2;
    ei = 0; im = 0; n = 0;
    for (int i = 0; i < 2; i++)
      if (creq[i]) begin
        ei[i*2 +: 2] = 2'((mtail + n) % 4);
        im[i*2 +: 2] = 2'b11;
        n++;
      end
    chk("src_tag", 32'(stag), 32'(et));
    chk("src_ready", 32'(srdy), 32'(er));
    chk("told", 32'(told_o), 32'(eo));
    chk("ckpt_full", 32'(full), 32'(ef));
    if (!rst && !rb && !rs && !ef && creq != 0) chk("ckpt_id", 32'(cid & im), 32'(ei));
    @(posedge clk);
    if (rst) model_reset(0);
    else if (rb) model_reset(1);
    else if (rs) begin
      for (int d = 0; d < 32; d++) begin
        mm[d] = sm[rid][d];
        mr[d] = sr[rid][d] | mhit(sm[rid][d]);
      end
      foreach (ckq[q]) for (int d = 0; d < 32; d++) sr[ckq[q]][d] |= mhit(sm[ckq[q]][d]);
      while (ckq.size() > 0 && ckq[$] != int'(rid)) void'(ckq.pop_back());
      if (ckq.size() > 0) void'(ckq.pop_back());
      mtail = int'(rid);
    end else begin
      foreach (ckq[q]) for (int d = 0; d < 32; d++) sr[ckq[q]][d] |= mhit(sm[ckq[q]][d]);
      for (int d = 0; d < 32; d++) mr[d] |= mhit(mm[d]);
      if (rel && ckq.size() > 0) void'(ckq.pop_front());
      for (int i = 0; i < 2; i++) begin
        if (rv[i]) begin
          mm[rdest[i*5 +: 5]] = rtag[i*6 +: 6];
          mr[rdest[i*5 +: 5]] = 1'b0;
        end
        if (creq[i] && !ef) begin
          id = mtail;
          for (int d = 0; d < 32; d++) begin
            sm[id][d] = mm[d];
            sr[id][d] = mr[d];
          end
          ckq.push_back(id);
          mtail = (mtail + 1) % 4;
        end
      end
    end
    #1;
  endtask

  initial begin
    tv[0] = '{rv: 2'b00, dest: {5'd9, 5'd4}, tag: 12'd0, src: {5'd31, 5'd0, 5'd7, 5'd3}, cv: 2'b00, ct: 12'd0,
              e_tag: {6'd31, 6'd0, 6'd7, 6'd3}, e_rdy: 4'b1111, e_told: {6'd9, 6'd4}};
    tv[1] = '{rv: 2'b11, dest: {5'd5, 5'd5}, tag: {6'd41, 6'd40}, src: {5'd1, 5'd5, 5'd2, 5'd5}, cv: 2'b00, ct: 12'd0,
              e_tag: {6'd1, 6'd40, 6'd2, 6'd5}, e_rdy: 4'b1011, e_told: {6'd40, 6'd5}};
    tv[2] = '{rv: 2'b00, dest: {5'd5, 5'd5}, tag: 12'd0, src: {5'd0, 5'd5, 5'd2, 5'd5}, cv: 2'b00, ct: 12'd0,
              e_tag: {6'd0, 6'd41, 6'd2, 6'd41}, e_rdy: 4'b1010, e_told: {6'd41, 6'd41}};
    tv[3] = '{rv: 2'b01, dest: {5'd0, 5'd2}, tag: {6'd0, 6'd45}, src: {5'd3, 5'd2, 5'd2, 5'd2}, cv: 2'b00, ct: 12'd0,
              e_tag: {6'd3, 6'd45, 6'd2, 6'd2}, e_rdy: 4'b1011, e_told: {6'd0, 6'd2}};
    tv[4] = '{rv: 2'b00, dest: {5'd5, 5'd2}, tag: 12'd0, src: {5'd9, 5'd5, 5'd2, 5'd2}, cv: 2'b01, ct: {6'd41, 6'd45},
              e_tag: {6'd9, 6'd41, 6'd45, 6'd45}, e_rdy: 4'b1011, e_told: {6'd41, 6'd45}};
    tv[5] = '{rv: 2'b00, dest: {5'd2, 5'd2}, tag: 12'd0, src: {5'd31, 5'd0, 5'd5, 5'd2}, cv: 2'b00, ct: 12'd0,
              e_tag: {6'd31, 6'd0, 6'd41, 6'd45}, e_rdy: 4'b1101, e_told: {6'd45, 6'd45}};
    tv[6] = '{rv: 2'b11, dest: {5'd7, 5'd7}, tag: {6'd11, 6'd10}, src: {5'd9, 5'd7, 5'd5, 5'd7}, cv: 2'b11, ct: {6'd41, 6'd10},
              e_tag: {6'd9, 6'd10, 6'd41, 6'd7}, e_rdy: 4'b1011, e_told: {6'd10, 6'd7}};
    tv[7] = '{rv: 2'b00, dest: {5'd5, 5'd7}, tag: 12'd0, src: {5'd7, 5'd2, 5'd5, 5'd7}, cv: 2'b00, ct: 12'd0,
              e_tag: {6'd11, 6'd45, 6'd41, 6'd11}, e_rdy: 4'b0110, e_told: {6'd41, 6'd11}};
    clr();
    for (int d = 0; d < 32; d++) rrat[d*6 +: 6] = 6'(d);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset(0);
    #2 chk("reset_full", 32'(full), 32'd0);
    for (int v = 0; v < 8; v++) begin
      clr();
      rv = tv[v].rv; rdest = tv[v].dest; rtag = tv[v].tag; srca = tv[v].src; cv = tv[v].cv; ct = tv[v].ct;
      #2;
      chk($sformatf("vec%0d_tag", v), 32'(stag), 32'(tv[v].e_tag));
      chk($sformatf("vec%0d_rdy", v), 32'(srdy), 32'(tv[v].e_rdy));
      chk($sformatf("vec%0d_told", v), 32'(told_o), 32'(tv[v].e_told));
      tick();
    end
    clr(); creq = 2'b11; #2;
    chk("alloc_a_id", 32'(cid), 32'({2'd1, 2'd0}));
    tick();
    clr(); creq = 2'b11; #2;
    chk("alloc_b_id", 32'(cid), 32'({2'd3, 2'd2}));
    chk("alloc_b_full", 32'(full), 32'd0);
    tick();
    clr(); #2;
    chk("four_full", 32'(full), 32'd1);
    rel = 1; tick();
    clr(); #2;
    chk("rel1_full", 32'(full), 32'd1);
    rel = 1; tick();
    clr(); #2;
    chk("rel2_full", 32'(full), 32'd0);
    rel = 1; tick();
    clr(); rel = 1; tick();
    clr(); rel = 1; tick();
    clr(); rv = 2'b01; rdest = {5'd0, 5'd9}; rtag = {6'd0, 6'd50}; creq = 2'b11; #2;
    chk("wrap_id", 32'(cid), 32'({2'd1, 2'd0}));
    tick();
    clr(); rv = 2'b01; rdest = {5'd0, 5'd9}; rtag = {6'd0, 6'd52}; tick();
    clr(); cv = 2'b01; ct = {6'd0, 6'd50}; srca = {15'd0, 5'd9}; #2;
    chk("r9_young_tag", 32'(stag[5:0]), 32'd52);
    chk("r9_young_rdy", 32'(srdy[0]), 32'd0);
    tick();
    clr(); rs = 1; rid = 2'd1; rel = 1; rv = 2'b01; rdest = {5'd0, 5'd9}; rtag = {6'd0, 6'd60}; tick();
    clr(); srca = {15'd0, 5'd9}; creq = 2'b01; #2;
    chk("restore_tag", 32'(stag[5:0]), 32'd50);
    chk("restore_rdy", 32'(srdy[0]), 32'd1);
    chk("restore_full", 32'(full), 32'd0);
    chk("restore_tail_id", 32'(cid[1:0]), 32'd1);
    tick();
    clr(); rb = 1; rs = 1; rid = 2'd0; creq = 2'b11; rv = 2'b11; rdest = {5'd4, 5'd3}; rtag = {6'd21, 6'd20}; tick();
    clr(); srca = {5'd7, 5'd2, 5'd5, 5'd9}; creq = 2'b11; #2;
    chk("rollback_tag", 32'(stag), 32'({6'd7, 6'd2, 6'd5, 6'd9}));
    chk("rollback_rdy", 32'(srdy), 32'hf);
    chk("rollback_full", 32'(full), 32'd0);
    chk("rollback_id", 32'(cid), 32'({2'd1, 2'd0}));
    tick();
    clr(); rv = 2'b11; rdest = {5'd2, 5'd1}; rtag = {6'd31, 6'd30}; creq = 2'b11; tick();
    clr(); rst = 1; rv = 2'b11; rdest = {5'd4, 5'd3}; rtag = {6'd33, 6'd32}; tick();
    rst = 0; clr(); srca = {5'd4, 5'd3, 5'd2, 5'd1}; #2;
    chk("midreset_tag", 32'(stag), 32'({6'd4, 6'd3, 6'd2, 6'd1}));
    chk("midreset_rdy", 32'(srdy), 32'hf);
    chk("midreset_full", 32'(full), 32'd0);
    tick();
    for (int n = 0; n < 600; n++) begin
      clr();
      rv = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        rdest[i*5 +: 5] = 5'($urandom_range(0, 7));
        rtag[i*6 +: 6] = 6'($urandom_range(32, 47));
      end
      for (int s = 0; s < 4; s++) srca[s*5 +: 5] = 5'($urandom_range(0, 9));
      cv = 2'($urandom);
      for (int c = 0; c < 2; c++) ct[c*6 +: 6] = 6'($urandom_range(0, 47));
      if (ckq.size() <= 2) creq = 2'($urandom);
      rel = $urandom_range(0, 3) == 0;
      if (ckq.size() > 0 && $urandom_range(0, 9) == 0) begin
        rs = 1;
        rid = 2'(ckq[$urandom_range(0, ckq.size() - 1)]);
      end
      if ($urandom_range(0, 39) == 0) begin
        rb = 1;
        for (int d = 0; d < 32; d++) rrat[d*6 +: 6] = 6'($urandom_range(0, 63));
      end
      rst = $urandom_range(0, 149) == 0;
      tick();
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
